// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector with IDLE/RUN/DONE run control.
// The pattern is loaded over a config handshake, then matches are counted on gated serial beats.
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAXLEN-1:0]            cfg_pattern,
    input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
    input  logic [CNTW-1:0]              cfg_target,
    input  logic                         cfg_overlap,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         hit,
    output logic [CNTW-1:0]              match_count,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   dbg_state
);
    localparam int LENW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [CNTW-1:0]   tgt_q, tgt_d;
    logic              ovl_q, ovl_d;
    logic [MAXLEN-1:0] hist_q, hist_d;
    logic [LENW-1:0]   fill_q, fill_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              hit_q, hit_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;

    logic [MAXLEN-1:0] hist_nx;
    logic [MAXLEN-1:0] len_mask;
    logic [LENW-1:0]   fill_nx;
    logic [CNTW-1:0]   cnt_nx;
    logic              match;

    // Config transfers on a cycle where cfg_valid && cfg_ready are both high at the rising edge;
    // cfg_ready is high only in IDLE, so a config can never change under a running scan.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        rdy_d   = rdy_q;

        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hist_nx = {hist_q[MAXLEN-2:0], in};
        fill_nx = (fill_q == LENW'(MAXLEN)) ? fill_q : fill_q + 1'b1;
        match   = (fill_nx >= len_q) && ((hist_nx & len_mask) == (pat_q & len_mask));
        cnt_nx  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    pat_d = cfg_pattern;
                    tgt_d = cfg_target;
                    ovl_d = cfg_overlap;
                    if (cfg_len == '0)
                        len_d = LENW'(1);
                    else if (cfg_len > LENW'(MAXLEN))
                        len_d = LENW'(MAXLEN);
                    else
                        len_d = cfg_len;
                end
                if (start) begin
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    hist_d = hist_nx;
                    fill_d = fill_nx;
                    if (match) begin
                        hit_d = 1'b1;
                        cnt_d = cnt_nx;
                        // Non-overlapping: the next match must be built from fresh bits only.
                        if (!ovl_q) fill_d = '0;
                        if ((tgt_q != '0) && (cnt_nx == tgt_q)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign cfg_ready   = rdy_q;
    assign hit         = hit_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign match_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random runs checked against a bit-list model.
module tb_seq_det_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;
  localparam int LENW   = $clog2(MAXLEN + 1);
  localparam int EW     = 16 + 1 + CNTW;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic [CNTW-1:0]   cfg_target;
  logic              cfg_overlap;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_bit;
  logic              hit;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  seq_det_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_overlap(cfg_overlap),
    .start(start), .abort(abort), .in_valid(in_valid), .in(in_bit),
    .hit(hit), .match_count(match_count), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // expected hit record: {cycle of hit, done flag, match_count}
  logic [EW-1:0] exp_q[$];

  // behavioural reference: bit list since start, bits since last match boundary
  bit              m_run;
  logic [MAXLEN-1:0] m_pat;
  int              m_len;
  int              m_tgt;
  bit              m_ovl;
  bit              m_bits[$];
  int              m_since;
  int              m_count;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m_run = 0; m_pat = '0; m_len = 0; m_tgt = 0; m_ovl = 0;
    m_bits.delete(); m_since = 0; m_count = 0;
  endtask

  task automatic model_beat(input bit b);
    bit is_match;
    bit fin;
    m_bits.push_back(b);
    if (m_bits.size() > 32) void'(m_bits.pop_front());
    m_since++;
    is_match = (m_since >= m_len);
    if (is_match) begin
      for (int i = 0; i < m_len; i++)
        if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) is_match = 0;
    end
    if (is_match) begin
      if (m_count < (1 << CNTW) - 1) m_count++;
      if (!m_ovl) m_since = 0;
      fin = (m_tgt != 0) && (m_count == m_tgt);
      exp_q.push_back({16'(edge_cnt + 1), fin, CNTW'(m_count)});
      if (fin) m_run = 0;
    end
  endtask

  // driver tasks: inputs change #1 after the rising edge
  task automatic step(input bit v, input bit b, input bit ab);
    in_valid = v; in_bit = b; abort = ab;
    if (m_run) begin
      if (ab) m_run = 0;
      else if (v) model_beat(b);
    end
    @(posedge clk); #1;
    in_valid = 0; abort = 0;
    chk("busy", busy, m_run);
    chk("match_count", match_count, m_count);
  endtask

  task automatic cfg_start(input logic [MAXLEN-1:0] pat, input int len, input int tgt,
                           input bit ovl, input bit st);
    cfg_valid = 1; cfg_pattern = pat; cfg_len = LENW'(len);
    cfg_target = CNTW'(tgt); cfg_overlap = ovl; start = st;
    if (!m_run) begin
      m_pat = pat; m_tgt = tgt; m_ovl = ovl;
      m_len = (len == 0) ? 1 : (len > MAXLEN) ? MAXLEN : len;
      if (st) begin
        m_run = 1; m_bits.delete(); m_since = 0; m_count = 0;
      end
    end
    @(posedge clk); #1;
    cfg_valid = 0; start = 0;
    chk("busy", busy, m_run);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    exp_q.delete();
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i], 0);
  endtask

  task automatic end_run(input string tag);
    if (m_run) step(0, 0, 1);
    step(0, 0, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_pending_hits"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // scoreboard monitor: pops on every hit, flags missing or stray pulses
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (hit) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL hit_unexpected: got hit=1 expected none (cycle %0d)", edge_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("hit_cycle", edge_cnt & 16'hffff, int'(e[EW-1 -: 16]));
        chk("hit_done", done, e[CNTW]);
        chk("hit_count", match_count, e[CNTW-1:0]);
      end
    end else begin
      if (done) begin
        n_chk++;
        $display("FAIL done_without_hit: got done=1 expected 0 (cycle %0d)", edge_cnt);
      end
      if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 16]) < (edge_cnt & 16'hffff)) begin
        n_chk++;
        $display("FAIL hit_missing: got none expected hit at cycle %0d", exp_q[0][EW-1 -: 16]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    cfg_overlap = 0; start = 0; abort = 0; in_valid = 0; in_bit = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);

    // 1: overlapping, no target
    cfg_start(8'b0110, 4, 0, 1, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    stream(16'b0110110, 7);
    step(0, 0, 0);
    chk("t1_count", match_count, 2);
    chk("t1_busy", busy, 1);
    end_run("t1");

    // 2: non-overlapping
    cfg_start(8'b0110, 4, 0, 0, 1);
    stream(16'b0110110, 7);
    step(0, 0, 0);
    chk("t2a_count", match_count, 1);
    end_run("t2a");
    cfg_start(8'b0110, 4, 0, 0, 1);
    stream(16'b01100110, 8);
    step(0, 0, 0);
    chk("t2b_count", match_count, 2);
    end_run("t2b");

    // 3: target reached
    cfg_start(8'b0110, 4, 2, 1, 1);
    stream(16'b011011, 6);
    step(1, 0, 0);
    chk("t3_done", done, 1);
    chk("t3_hit", hit, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ready_in_done", cfg_ready, 0);
    step(0, 0, 0);
    chk("t3_ready_after", cfg_ready, 1);
    stream(16'b0110, 4);
    chk("t3_count_hold", match_count, 2);
    end_run("t3");

    // 4: gaps with in toggling while invalid
    cfg_start(8'b0110, 4, 0, 1, 1);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] p;
      p = 4'b0110;
      repeat ($urandom_range(1, 3)) step(0, $urandom_range(0, 1), 0);
      step(1, p[i], 0);
    end
    step(0, 1, 0);
    chk("t4_count", match_count, 1);
    end_run("t4");

    // 5: abort on completing beat, then length-0 config
    cfg_start(8'b0110, 4, 0, 1, 1);
    stream(16'b011, 3);
    step(1, 0, 1);
    chk("t5_count", match_count, 0);
    chk("t5_ready", cfg_ready, 1);
    step(0, 0, 0);
    chk("t5_no_hit", hit, 0);
    cfg_start(8'b0000_0001, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 1), 0);
    end_run("t5b");

    // 6: reset mid-run, then config and start together
    cfg_start(8'b0110, 4, 0, 1, 1);
    stream(16'b0110, 4);
    step(0, 0, 0);
    chk("t6_count_pre", match_count, 1);
    do_reset();
    chk("t6_count", match_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cfg_ready, 1);
    cfg_start(8'b101, 3, 0, 1, 1);
    stream(16'b10101101, 8);
    end_run("t6");

    // random runs
    for (int r = 0; r < 40; r++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
      cfg_start(MAXLEN'($urandom), len, $urandom_range(0, 3), $urandom_range(0, 1), 1);
      for (int c = 0; c < $urandom_range(20, 60); c++)
        step($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 49) == 0);
      end_run("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern detector with a run controller. It accepts a pattern of up to MAXLEN bits through a ready/valid config handshake, then arms on start. While armed it scans a gated serial bit stream and counts matches, with overlapping or non-overlapping detection. It stops on a target match count or on abort. It is the configurable successor to the fixed-pattern FSM detectors and sits between a control host and a serial input.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNTW, 8, width of match counter and target

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cfg_valid  input  1  config offer
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready
cfg_pattern  input  MAXLEN  pattern; bit [len-1] is received first, bit [0] last
cfg_len  input  $clog2(MAXLEN+1)  pattern length
cfg_target  input  CNTW  stop after this many matches; 0 = run until abort
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
start  input  1  arm detector (pulse)
abort  input  1  stop run (pulse)
in_valid  input  1  serial bit qualifier
in  input  1  serial data bit
hit  output  1  one-cycle match pulse
match_count  output  CNTW  matches in current/last run
busy  output  1  high while armed
done  output  1  one-cycle pulse on target reached

Behaviour:
- Reset (sync, rst=1 at edge):
  - state IDLE; cfg_ready=1; hit=0; done=0; busy=0; match_count=0.
  - Stored pattern/len/target/overlap=0; history and fill counter=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - cfg_ready=1. A config handshake latches all cfg_* fields.
  - cfg_len=0 is stored as 1; cfg_len>MAXLEN is stored as MAXLEN.
  - start clears history, fill, match_count and done, then enters RUN; busy=1 from the next cycle.
  - start and a config handshake in the same cycle: the new config is used for the run.
- RUN:
  - cfg_ready=0; cfg_valid and start are ignored.
  - On an in_valid beat: hist <= {hist[MAXLEN-2:0], in}; fill <= min(fill+1, MAXLEN).
  - in_valid=0: hist, fill and outputs hold; no hit.
  - Match on a beat: (fill_next >= len) and hist_next[len-1:0] == pattern[len-1:0].
  - On a match, in the cycle after the beat: hit=1 for exactly one cycle, and match_count increments, saturating at 2^CNTW-1.
  - Non-overlapping mode: a match also sets fill to 0, so the next match needs len fresh bits. Overlapping mode: fill is unchanged.
  - Target reached (target!=0 and new count == target): go to DONE on the same edge that raises hit.
- DONE:
  - One cycle: done=1 (coincident with the final hit), busy=0.
  - Then IDLE. Beats during DONE are ignored.
- abort during RUN:
  - Next state IDLE; busy=0; no done.
  - match_count holds its value.
  - A beat arriving in the abort cycle is discarded: no hit, no count.
  - abort in IDLE/DONE is ignored.
- match_count holds after DONE/abort until the next start.
- Latency: in_valid beat to hit = 1 cycle; start to busy = 1 cycle.
- rst mid-run: every output returns to its reset value at that edge; the stored config is lost.

Test Plan:
1. Config pattern=0110, len=4, overlap=1, target=0; stream 0,1,1,0,1,1,0 -> hit the cycle after beats 4 and 7; match_count=2; busy stays 1.
2. Same pattern, overlap=0; stream 0110110 -> single hit after beat 4, count=1. Stream 01100110 -> hits after beats 4 and 8, count=2.
3. overlap=1, target=2; stream 0110110 then 0110 -> done and hit together the cycle after beat 7; busy=0; cfg_ready=1 next cycle; later bits give no hit; count stays 2.
4. Stream 0110 with in_valid=0 gaps of 1-3 cycles (in toggling during gaps) -> exactly one hit, one cycle after the 4th valid beat.
5. abort asserted in the cycle of the completing 4th beat -> no hit, count=0, IDLE, cfg_ready=1. Separately, cfg_len=0 with pattern bit0=1 -> a hit for every valid '1'.
6. rst held high one edge mid-run after count=1 -> match_count=0, busy=0, cfg_ready=1. Then a new config + start in the same cycle -> run uses the new pattern.
